// File: rtl/interval_sequencer.sv
// interval_sequencer: plays back a small table of interval lengths into a
// programmable up-counter. Each interval is a one-cycle counter clear
// followed by a wait for the counter's limit flag. Progress and completion
// are reported to the top-level FSM; an optional repeat mode loops the table
// until abort.
module interval_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      num_steps,
  input  logic             repeat_en,
  input  logic             start,
  input  logic             abort,
  input  logic             limit_in,
  output logic [WIDTH-1:0] n_out,
  output logic             sreset_out,
  output logic [AW-1:0]    step_idx,
  output logic             step_pulse,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] table_d [DEPTH];
  logic [AW:0]      steps_q, steps_d;
  logic [WIDTH-1:0] n_out_q, n_out_d;
  logic             sreset_q, sreset_d;
  logic [AW-1:0]    step_idx_q, step_idx_d;
  logic             step_pulse_q, step_pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [AW:0]      steps_clamped;
  logic [AW-1:0]    next_idx;
  logic             last_step;

  assign steps_clamped = (num_steps > DEPTH_C) ? DEPTH_C : num_steps;
  assign next_idx      = step_idx_q + AW'(1);
  assign last_step     = (({1'b0, step_idx_q} + ONE_C) == steps_q);

  // Table write port: accepted in any state, lands at the clock edge.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    table_d = table_q;
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      table_d[wr_addr] = wr_data;
    end
  end

  // Next-state and registered-output computation; loads read table_q, so a
  // same-edge write to the loaded entry is seen only on its next playback.
  always_comb begin
    state_d      = state_q;
    steps_d      = steps_q;
    n_out_d      = n_out_q;
    step_idx_d   = step_idx_q;
    step_pulse_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          steps_d = steps_clamped;
          if (steps_clamped == '0) begin
            state_d = S_DONE;
          end else begin
            step_idx_d = '0;
            n_out_d    = table_q[0];
            state_d    = S_CLEAR;
          end
        end
      end
      // Counter's limit is sticky until this clear, so limit_in is ignored.
      S_CLEAR: begin
        state_d = abort ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (limit_in) begin
          step_pulse_d = 1'b1;
          if (!last_step) begin
            step_idx_d = next_idx;
            n_out_d    = table_q[next_idx];
            state_d    = S_CLEAR;
          end else if (repeat_en) begin
            step_idx_d = '0;
            n_out_d    = table_q[0];
            state_d    = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are decoded from the state being entered so that the
    // flops present them in the same cycle as that state.
    sreset_d = (state_d == S_CLEAR) || (state_d == S_DONE);
    busy_d   = (state_d == S_CLEAR) || (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
  end

  // State, table and output registers with synchronous reset.
  always_ff @(posedge mclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      steps_q      <= '0;
      n_out_q      <= '0;
      sreset_q     <= 1'b0;
      step_idx_q   <= '0;
      step_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      // NOTE: the table is small and must read back as zero after reset,
      // so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      steps_q      <= steps_d;
      n_out_q      <= n_out_d;
      sreset_q     <= sreset_d;
      step_idx_q   <= step_idx_d;
      step_pulse_q <= step_pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  assign n_out      = n_out_q;
  assign sreset_out = sreset_q;
  assign step_idx   = step_idx_q;
  assign step_pulse = step_pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/interval_sequencer.md
Name: interval_sequencer

Overview:
- Controller that drives the programmable up-counter from the far side of its interface: it supplies `n`, issues `sreset`, and consumes `limit`.
- Holds a small table of interval lengths. On `start`, it plays them back in order: each interval is a counter clear followed by a wait for `limit`.
- Reports step progress and completion to the top-level FSM.
- Optional repeat mode loops the table until `abort`.

Parameters:
- WIDTH, 8, width of interval values and `n_out` (matches counter `n`)
- DEPTH, 4, number of table entries
- AW, 2, table address width (log2 DEPTH)

Ports:
- mclk  input  1  clock
- reset  input  1  sync active-high reset
- wr_en  input  1  table write strobe
- wr_addr  input  AW  table write index
- wr_data  input  WIDTH  interval value written to table[wr_addr]
- num_steps  input  AW+1  entries to play, 0..DEPTH; values >DEPTH clamp to DEPTH
- repeat_en  input  1  1 = loop back to entry 0 after the last step
- start  input  1  begin sequence (level sampled, acted on only in IDLE)
- abort  input  1  terminate sequence
- limit_in  input  1  counter limit flag
- n_out  output  WIDTH  interval currently applied to the counter
- sreset_out  output  1  one-cycle counter clear
- step_idx  output  AW  index of the active entry
- step_pulse  output  1  one-cycle pulse when an interval completes
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse at sequence end

Behaviour:
- Reset (reset, synchronous, active-high; clock mclk):
  - state=IDLE; all table entries=0.
  - n_out=0, sreset_out=0, step_idx=0, step_pulse=0, busy=0, done=0.
  - Latched step count = 0.
- All outputs are registered and reflect the state entered on the preceding edge.
- Table writes:
  - Accepted in any state; table[wr_addr] is updated at the edge.
  - n_out is loaded only on entry to CLEAR. A write to the active entry takes effect on that entry's next playback.
  - A same-edge write and load of one entry: the load uses the pre-write value.
- States:
  - IDLE
    - busy=0.
    - start=1 and abort=0: latch clamp(num_steps). If it is 0, go to DONE. Otherwise step_idx=0, n_out=table[0], go to CLEAR.
    - start=1 and abort=1: stay in IDLE.
  - CLEAR
    - sreset_out=1, busy=1, for exactly one cycle.
    - limit_in is ignored, because the counter's limit is sticky until cleared.
    - Go to RUN.
  - RUN
    - sreset_out=0, busy=1. Wait indefinitely for limit_in=1.
    - On limit_in=1, assert step_pulse=1 for one cycle, then:
      - Not the last entry: step_idx+1, n_out=table[step_idx+1], go to CLEAR.
      - Last entry with repeat_en=1: step_idx=0, n_out=table[0], go to CLEAR. step_idx wraps with no gap cycle.
      - Last entry with repeat_en=0: go to DONE.
  - DONE
    - done=1, sreset_out=1, busy=0 for one cycle. This leaves the counter cleared.
    - Go to IDLE.
- abort:
  - In CLEAR or RUN: next state is DONE (done=1, sreset_out=1). step_pulse is not asserted, even if limit_in=1 in the same cycle.
  - Ignored in DONE and IDLE.
- start while busy=1: ignored. repeat_en and num_steps changes mid-sequence: ignored; latched at start.
  - Exception: repeat_en is sampled live at the last step, so clearing it ends a looping run cleanly.
- Step latency: every step takes ≥2 cycles (CLEAR + ≥1 RUN cycle). step_pulse coincides with the next step's sreset_out=1, or with done.
- n_out=0 entry: legal. The counter hits its limit immediately and the step completes as soon as limit_in rises.

Test Plan:
- Reset, then table={3,5,2,7}, num_steps=3, repeat_en=0, start. Model the counter (limit one cycle after count≥n) → n_out sequence 3,5,2; three step_pulses with step_idx 0,1,2; sreset_out high 4 times (3×CLEAR + DONE); done pulse once; busy low afterwards; entry 3 unused.
- num_steps=0, start → DONE on the next cycle: done=1, busy never 1, no step_pulse.
- num_steps=2, repeat_en=1, table={1,2}, run 3 loops then abort in RUN with limit_in=1 on the same cycle → step_idx pattern 0,1,0,1,0,1,0; no step_pulse on the abort cycle; done=1; IDLE next.
- Mid-sequence write table[1]=9 while step 1 is in RUN with n_out=5 → n_out stays 5 for that step; the next loop applies 9.
- Hold limit_in=1 constantly, num_steps=2 → each step is exactly 2 cycles (CLEAR+RUN); no step completes in CLEAR; done 5 cycles after start.
- Assert reset during RUN → the next cycle shows all outputs 0, state IDLE, table cleared; start afterwards plays n_out=0.
